// File: rtl/ntt_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ntt_stage_sequencer
// Purpose  : Pass sequencer for an NTT butterfly array: read rows, twiddle
//            indices, write-back via a latency-matched delay line.
// Options  : define POINTWISE_MUL_EN to append a pointwise-multiply pass.
// Revision : 1.0
// ============================================================================
module ntt_stage_sequencer #(
    parameter int ROWS       = 16,
    parameter int NUM_STAGES = 8,
    parameter int BF_LATENCY = 4,
    parameter int LUT_SIZE   = 1360
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    output logic                              rd_en,
    output logic [$clog2(ROWS)-1:0]           rd_addr,
    output logic [$clog2(LUT_SIZE):0]         w_idx,
    output logic                              mode,
    output logic                              wr_en,
    output logic [$clog2(ROWS)-1:0]           wr_addr,
    output logic [$clog2(NUM_STAGES+1)-1:0]   stage,
    output logic                              busy,
    output logic                              done
);

    localparam int ADDR_W  = $clog2(ROWS);
    localparam int WIDX_W  = $clog2(LUT_SIZE) + 1;
    localparam int STAGE_W = $clog2(NUM_STAGES + 1);
    localparam int DLY     = 1 + BF_LATENCY;
`ifdef POINTWISE_MUL_EN
    localparam int PASSES  = NUM_STAGES + 1;
`else
    localparam int PASSES  = NUM_STAGES;
`endif
    localparam logic [ADDR_W-1:0]  LAST_ROW  = ADDR_W'(ROWS - 1);
    localparam logic [STAGE_W-1:0] LAST_PASS = STAGE_W'(PASSES - 1);

    generate
        if (PASSES * ROWS > LUT_SIZE) begin : g_lut_overflow
            $error("ntt_stage_sequencer: twiddle table too small for PASSES*ROWS");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t              r_state;
    logic [DLY-1:0]      r_dly_en;
    logic [ADDR_W-1:0]   r_dly_addr [DLY];
    logic                w_last_wr;
    logic [WIDX_W-1:0]   w_twiddle;

    assign wr_en     = r_dly_en[DLY-1];
    assign wr_addr   = r_dly_addr[DLY-1];
    assign w_last_wr = wr_en && (wr_addr == LAST_ROW);
    assign w_twiddle = WIDX_W'(stage) * WIDX_W'(ROWS) + WIDX_W'(rd_addr);

    // rd_addr is forced to 0 outside ISSUE, so idle slots carry address 0 too.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dly_en <= '0;
            for (int i = 0; i < DLY; i++) begin
                r_dly_addr[i] <= '0;
            end
        end else begin
            r_dly_en[0]   <= rd_en;
            r_dly_addr[0] <= rd_addr;
            for (int i = 1; i < DLY; i++) begin
                r_dly_en[i]   <= r_dly_en[i-1];
                r_dly_addr[i] <= r_dly_addr[i-1];
            end
        end
    end

    // Twiddle index lines up with the read data, one cycle after rd_en.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_idx <= '0;
        end else if (rd_en) begin
            w_idx <= w_twiddle;
        end else begin
            w_idx <= '0;
        end
    end

`ifdef POINTWISE_MUL_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode <= 1'b0;
        end else begin
            mode <= rd_en && (stage == STAGE_W'(NUM_STAGES));
        end
    end
`else
    assign mode = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            stage   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ISSUE;
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                        stage   <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (rd_addr == LAST_ROW) begin
                        rd_en   <= 1'b0;
                        rd_addr <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Next pass may only read once the previous pass is fully written.
                    if (w_last_wr) begin
                        if (stage == LAST_PASS) begin
                            r_state <= S_FINISH;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE;
                            rd_en   <= 1'b1;
                            stage   <= stage + 1'b1;
                        end
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    stage   <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    rd_en   <= 1'b0;
                    rd_addr <= '0;
                    stage   <= '0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ntt_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntt_stage_sequencer
// Purpose  : Self-checking bench: cycle-accurate scoreboard plus spot table.
// Revision : 1.0
// ============================================================================
module tb_ntt_stage_sequencer;

    localparam int ROWS = 4;
    localparam int NS   = 2;
    localparam int BFL  = 3;
    localparam int LUT  = 1360;
    localparam int P    = ROWS + 1 + BFL;
`ifdef POINTWISE_MUL_EN
    localparam int NP   = NS + 1;
`else
    localparam int NP   = NS;
`endif
    localparam int NCYC = NP * P + 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        rd_en;
    logic [1:0]  rd_addr;
    logic [11:0] w_idx;
    logic        mode;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [1:0]  stage;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    ntt_stage_sequencer #(
        .ROWS(ROWS), .NUM_STAGES(NS), .BF_LATENCY(BFL), .LUT_SIZE(LUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .rd_en(rd_en), .rd_addr(rd_addr), .w_idx(w_idx), .mode(mode),
        .wr_en(wr_en), .wr_addr(wr_addr), .stage(stage),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rd_en;
        logic [1:0]  rd_addr;
        logic [11:0] w_idx;
        logic        mode;
        logic        wr_en;
        logic [1:0]  wr_addr;
        logic [1:0]  stage;
        logic        busy;
        logic        done;
    } obs_t;

    typedef struct {
        int          cyc;
        logic        rd_en;
        logic        wr_en;
        logic        done;
        logic        busy;
        logic [11:0] w_idx;
        logic        mode;
    } vec_t;

    obs_t sb [$];
    obs_t trace [NCYC];

    // Expected outputs at cycle c, where cycle 0 follows the start sample.
    function automatic obs_t model(input int c);
        obs_t o;
        int   c1, c2;
        o = '0;
        if (c < NP * P && (c % P) < ROWS) begin
            o.rd_en   = 1'b1;
            o.rd_addr = 2'(c % P);
        end
        c1 = c - 1;
        if (c1 >= 0 && c1 < NP * P && (c1 % P) < ROWS) begin
            o.w_idx = 12'((c1 / P) * ROWS + (c1 % P));
            o.mode  = ((c1 / P) == NS);
        end
        c2 = c - (1 + BFL);
        if (c2 >= 0 && c2 < NP * P && (c2 % P) < ROWS) begin
            o.wr_en   = 1'b1;
            o.wr_addr = 2'(c2 % P);
        end
        if (c < NP * P)       o.stage = 2'(c / P);
        else if (c == NP * P) o.stage = 2'(NP - 1);
        o.busy = (c <= NP * P);
        o.done = (c == NP * P);
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.rd_en   = rd_en;
        o.rd_addr = rd_addr;
        o.w_idx   = w_idx;
        o.mode    = mode;
        o.wr_en   = wr_en;
        o.wr_addr = wr_addr;
        o.stage   = stage;
        o.busy    = busy;
        o.done    = done;
        return o;
    endfunction

    task automatic check_obs(input string name, input int c, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %h expected %h", name, c, got, exp);
        end
    endtask

    task automatic check_bit(input string name, input int c, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %b expected %b", name, c, got, exp);
        end
    endtask

    // Entered and left at posedge+1; restart_at < 0 means no extra start.
    task automatic run_seq(input string name, input int restart_at);
        obs_t got, exp;
        for (int c = 0; c < NCYC; c++) sb.push_back(model(c));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            start = (c == restart_at);
            @(negedge clk);
            got = sample();
            exp = sb.pop_front();
            trace[c] = got;
            check_obs(name, c, got, exp);
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    initial begin
        vec_t tbl [$];
        obs_t zero;
        zero = '0;

        tbl.push_back('{0,  1'b1, 1'b0, 1'b0, 1'b1, 12'd0, 1'b0});
        tbl.push_back('{1,  1'b1, 1'b0, 1'b0, 1'b1, 12'd0, 1'b0});
        tbl.push_back('{3,  1'b1, 1'b0, 1'b0, 1'b1, 12'd2, 1'b0});
        tbl.push_back('{4,  1'b0, 1'b1, 1'b0, 1'b1, 12'd3, 1'b0});
        tbl.push_back('{7,  1'b0, 1'b1, 1'b0, 1'b1, 12'd0, 1'b0});
        tbl.push_back('{8,  1'b1, 1'b0, 1'b0, 1'b1, 12'd0, 1'b0});
        tbl.push_back('{9,  1'b1, 1'b0, 1'b0, 1'b1, 12'd4, 1'b0});
        tbl.push_back('{12, 1'b0, 1'b1, 1'b0, 1'b1, 12'd7, 1'b0});
        tbl.push_back('{15, 1'b0, 1'b1, 1'b0, 1'b1, 12'd0, 1'b0});
`ifdef POINTWISE_MUL_EN
        tbl.push_back('{16, 1'b1, 1'b0, 1'b0, 1'b1, 12'd0, 1'b0});
        tbl.push_back('{17, 1'b1, 1'b0, 1'b0, 1'b1, 12'd8, 1'b1});
        tbl.push_back('{20, 1'b0, 1'b1, 1'b0, 1'b1, 12'd11, 1'b1});
        tbl.push_back('{24, 1'b0, 1'b0, 1'b1, 1'b1, 12'd0, 1'b0});
        tbl.push_back('{25, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0});
`else
        tbl.push_back('{16, 1'b0, 1'b0, 1'b1, 1'b1, 12'd0, 1'b0});
        tbl.push_back('{17, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0});
`endif

        // Held in reset: everything at zero.
        repeat (2) @(negedge clk);
        check_obs("reset_hold", 0, sample(), zero);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_seq("run_basic", -1);

        for (int i = 0; i < tbl.size(); i++) begin
            check_bit("tbl_rd_en", tbl[i].cyc, trace[tbl[i].cyc].rd_en, tbl[i].rd_en);
            check_bit("tbl_wr_en", tbl[i].cyc, trace[tbl[i].cyc].wr_en, tbl[i].wr_en);
            check_bit("tbl_done",  tbl[i].cyc, trace[tbl[i].cyc].done,  tbl[i].done);
            check_bit("tbl_busy",  tbl[i].cyc, trace[tbl[i].cyc].busy,  tbl[i].busy);
            check_bit("tbl_mode",  tbl[i].cyc, trace[tbl[i].cyc].mode,  tbl[i].mode);
            checks++;
            if (trace[tbl[i].cyc].w_idx !== tbl[i].w_idx) begin
                errors++;
                $display("FAIL tbl_w_idx cyc %0d got %0d expected %0d",
                         tbl[i].cyc, trace[tbl[i].cyc].w_idx, tbl[i].w_idx);
            end
        end

        // Start asserted mid-run must not disturb the sequence.
        run_seq("run_restart5", 5);

        // Asynchronous reset in cycle 6 of a run.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_obs("reset_midrun", 6, sample(), zero);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 2 * P; c++) begin
            @(negedge clk);
            check_obs("post_reset_idle", c, sample(), zero);
        end
        @(posedge clk); #1;

        run_seq("run_after_reset", -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
